// File: rtl/ldpc_iter_scheduler.sv
// Sequencing controller for the serial LDPC min-sum datapath: LLR load, syndrome, CN and VN passes.
// Define LDPC_SCHED_EARLY_TERM_EN to run a syndrome pass after every iteration and stop early.
module ldpc_iter_scheduler #(
  parameter int N            = 12,
  parameter int M            = 6,
  parameter int LOG2N        = 4,
  parameter int LOG2M        = 3,
  parameter int MAX_ITER     = 30,
  parameter int LOG2MAX_ITER = 5,
  parameter int PIPE_LAT     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    parity_fail,
  output logic [2:0]              phase,
  output logic                    busy,
  output logic                    llr_wr_en,
  output logic [LOG2N-1:0]        llr_addr,
  output logic                    syn_rd_en,
  output logic                    cn_rd_en,
  output logic                    cn_wr_en,
  output logic                    vn_rd_en,
  output logic                    vn_wr_en,
  output logic [LOG2M-1:0]        syn_idx,
  output logic [LOG2M-1:0]        cn_idx,
  output logic [LOG2M-1:0]        cn_wr_idx,
  output logic [LOG2N-1:0]        vn_idx,
  output logic [LOG2N-1:0]        vn_wr_idx,
  output logic                    done,
  output logic                    success,
  output logic [LOG2MAX_ITER-1:0] iterations
);

`ifdef LDPC_SCHED_EARLY_TERM_EN
  localparam bit EarlyTerm = 1'b1;
`else
  localparam bit EarlyTerm = 1'b0;
`endif

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLoad = 3'd1;
  localparam logic [2:0] StSyn  = 3'd2;
  localparam logic [2:0] StCn   = 3'd3;
  localparam logic [2:0] StVn   = 3'd4;
  localparam logic [2:0] StDone = 3'd5;

  localparam int CntRaw = $clog2(N + PIPE_LAT + 1);
  localparam int CW     = (CntRaw > LOG2N) ? CntRaw : LOG2N;

  localparam logic [CW-1:0]           LoadLast = CW'(N - 1);
  localparam logic [CW-1:0]           ChkLast  = CW'(M + PIPE_LAT - 1);
  localparam logic [CW-1:0]           VarLast  = CW'(N + PIPE_LAT - 1);
  localparam logic [CW-1:0]           NumChk   = CW'(M);
  localparam logic [CW-1:0]           NumVar   = CW'(N);
  localparam logic [LOG2MAX_ITER-1:0] IterMax  = LOG2MAX_ITER'(MAX_ITER);

  logic [2:0]              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [LOG2MAX_ITER-1:0] iter_q, iter_d, iter_inc;
  logic                    succ_q, succ_d;
  logic                    acc_q, acc_d, acc_now;
  logic                    flush;

  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    llr_wr_q, llr_wr_d;
  logic [LOG2N-1:0]        llr_addr_q, llr_addr_d;
  logic                    syn_rd_q, syn_rd_d;
  logic [LOG2M-1:0]        syn_idx_q, syn_idx_d;
  logic                    cn_rd_q, cn_rd_d;
  logic [LOG2M-1:0]        cn_idx_q, cn_idx_d;
  logic                    vn_rd_q, vn_rd_d;
  logic [LOG2N-1:0]        vn_idx_q, vn_idx_d;

  // Write-back delay lines: stage PIPE_LAT-1 is the strobe PIPE_LAT cycles after the read.
  logic [PIPE_LAT-1:0]     syn_dl, cn_dl, vn_dl;
  logic [LOG2M-1:0]        cn_idx_dl [PIPE_LAT];
  logic [LOG2N-1:0]        vn_idx_dl [PIPE_LAT];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    iter_d   = iter_q;
    succ_d   = succ_q;
    acc_d    = acc_q;
    flush    = 1'b0;
    acc_now  = acc_q | (syn_dl[PIPE_LAT-1] & parity_fail);
    iter_inc = (iter_q == IterMax) ? iter_q : iter_q + LOG2MAX_ITER'(1);
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start) begin
          state_d = StLoad;
          iter_d  = '0;
          succ_d  = 1'b0;
          acc_d   = 1'b0;
        end
      end
      StLoad: begin
        if (cnt_q == LoadLast) begin
          cnt_d   = '0;
          acc_d   = 1'b0;
          state_d = EarlyTerm ? StSyn : StCn;
        end
      end
      StSyn: begin
        acc_d = acc_now;
        if (cnt_q == ChkLast) begin
          cnt_d = '0;
          if (!acc_now) begin
            state_d = StDone;
            succ_d  = 1'b1;
          end else if (!EarlyTerm || (iter_q == IterMax)) begin
            state_d = StDone;
          end else begin
            state_d = StCn;
          end
        end
      end
      StCn: begin
        if (cnt_q == ChkLast) begin
          cnt_d   = '0;
          state_d = StVn;
        end
      end
      StVn: begin
        if (cnt_q == VarLast) begin
          cnt_d   = '0;
          acc_d   = 1'b0;
          iter_d  = iter_inc;
          state_d = (EarlyTerm || (iter_inc == IterMax)) ? StSyn : StCn;
        end
      end
      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
    if (abort && (state_q inside {StLoad, StSyn, StCn, StVn})) begin
      state_d = StDone;
      cnt_d   = '0;
      iter_d  = iter_q;
      succ_d  = 1'b0;
      flush   = 1'b1;
    end
  end

  // Strobes are computed from the next state so every output comes straight from a flop.
  always_comb begin
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
    llr_wr_d   = (state_d == StLoad);
    llr_addr_d = llr_wr_d ? cnt_d[LOG2N-1:0] : '0;
    syn_rd_d   = (state_d == StSyn) && (cnt_d < NumChk);
    syn_idx_d  = syn_rd_d ? cnt_d[LOG2M-1:0] : '0;
    cn_rd_d    = (state_d == StCn) && (cnt_d < NumChk);
    cn_idx_d   = cn_rd_d ? cnt_d[LOG2M-1:0] : '0;
    vn_rd_d    = (state_d == StVn) && (cnt_d < NumVar);
    vn_idx_d   = vn_rd_d ? cnt_d[LOG2N-1:0] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      iter_q     <= '0;
      succ_q     <= 1'b0;
      acc_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      llr_wr_q   <= 1'b0;
      llr_addr_q <= '0;
      syn_rd_q   <= 1'b0;
      syn_idx_q  <= '0;
      cn_rd_q    <= 1'b0;
      cn_idx_q   <= '0;
      vn_rd_q    <= 1'b0;
      vn_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      iter_q     <= iter_d;
      succ_q     <= succ_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      llr_wr_q   <= llr_wr_d;
      llr_addr_q <= llr_addr_d;
      syn_rd_q   <= syn_rd_d;
      syn_idx_q  <= syn_idx_d;
      cn_rd_q    <= cn_rd_d;
      cn_idx_q   <= cn_idx_d;
      vn_rd_q    <= vn_rd_d;
      vn_idx_q   <= vn_idx_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syn_dl <= '0;
      cn_dl  <= '0;
      vn_dl  <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        cn_idx_dl[i] <= '0;
        vn_idx_dl[i] <= '0;
      end
    end else if (flush) begin
      syn_dl <= '0;
      cn_dl  <= '0;
      vn_dl  <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        cn_idx_dl[i] <= '0;
        vn_idx_dl[i] <= '0;
      end
    end else begin
      syn_dl[0]    <= syn_rd_q;
      cn_dl[0]     <= cn_rd_q;
      vn_dl[0]     <= vn_rd_q;
      cn_idx_dl[0] <= cn_idx_q;
      vn_idx_dl[0] <= vn_idx_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        syn_dl[i]    <= syn_dl[i-1];
        cn_dl[i]     <= cn_dl[i-1];
        vn_dl[i]     <= vn_dl[i-1];
        cn_idx_dl[i] <= cn_idx_dl[i-1];
        vn_idx_dl[i] <= vn_idx_dl[i-1];
      end
    end
  end

  assign phase      = state_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign success    = succ_q;
  assign iterations = iter_q;
  assign llr_wr_en  = llr_wr_q;
  assign llr_addr   = llr_addr_q;
  assign syn_rd_en  = syn_rd_q;
  assign syn_idx    = syn_idx_q;
  assign cn_rd_en   = cn_rd_q;
  assign cn_idx     = cn_idx_q;
  assign vn_rd_en   = vn_rd_q;
  assign vn_idx     = vn_idx_q;
  assign cn_wr_en   = cn_dl[PIPE_LAT-1];
  assign cn_wr_idx  = cn_idx_dl[PIPE_LAT-1];
  assign vn_wr_en   = vn_dl[PIPE_LAT-1];
  assign vn_wr_idx  = vn_idx_dl[PIPE_LAT-1];

endmodule

// File: tb/tb_ldpc_iter_scheduler.sv
// Bench for ldpc_iter_scheduler: builds the expected per-cycle schedule of each frame from the
// pass structure and compares it with the DUT, plus directed done-time/success/iteration checks.
module tb_ldpc_iter_scheduler;
  localparam int N    = 12;
  localparam int M    = 6;
  localparam int P    = 2;
  localparam int MAXI = 30;

`ifdef LDPC_SCHED_EARLY_TERM_EN
  localparam bit EarlyTerm = 1'b1;
`else
  localparam bit EarlyTerm = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, abort, parity_fail;
  logic [2:0] phase;
  logic       busy, llr_wr_en, syn_rd_en, cn_rd_en, cn_wr_en, vn_rd_en, vn_wr_en;
  logic [3:0] llr_addr, vn_idx, vn_wr_idx;
  logic [2:0] syn_idx, cn_idx, cn_wr_idx;
  logic       done, success;
  logic [4:0] iterations;

  ldpc_iter_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .parity_fail(parity_fail),
    .phase      (phase),
    .busy       (busy),
    .llr_wr_en  (llr_wr_en),
    .llr_addr   (llr_addr),
    .syn_rd_en  (syn_rd_en),
    .cn_rd_en   (cn_rd_en),
    .cn_wr_en   (cn_wr_en),
    .vn_rd_en   (vn_rd_en),
    .vn_wr_en   (vn_wr_en),
    .syn_idx    (syn_idx),
    .cn_idx     (cn_idx),
    .cn_wr_idx  (cn_wr_idx),
    .vn_idx     (vn_idx),
    .vn_wr_idx  (vn_wr_idx),
    .done       (done),
    .success    (success),
    .iterations (iterations)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] phase;
    logic       busy;
    logic       llr_wr;
    logic [3:0] llr_addr;
    logic       syn_rd;
    logic [2:0] syn_idx;
    logic       cn_rd;
    logic [2:0] cn_idx;
    logic       cn_wr;
    logic [2:0] cn_wr_idx;
    logic       vn_rd;
    logic [3:0] vn_idx;
    logic       vn_wr;
    logic [3:0] vn_wr_idx;
    logic       done;
    logic       success;
    logic [4:0] iterations;
  } obs_t;

  typedef struct {
    int mode;      // 0 clean, 1 check 4 fails in first 3 SYN passes, 2 always fail, 3 random
    int abort_at;  // trace index of abort cycle, -1 none, -2 random
    int exp_done;  // cycles from start edge to done, 0 = not checked
    int exp_succ;
    int exp_iter;
  } vec_t;

  obs_t exp_tr [2048];
  bit   pf_tr  [2048];
  int   tr_len, done_idx, abort_idx;
  int   checks, errors;
  vec_t tab [8];
  int   ntab;

  function automatic obs_t sample_raw();
    obs_t a;
    a.phase = phase;       a.busy = busy;
    a.llr_wr = llr_wr_en;  a.llr_addr = llr_addr;
    a.syn_rd = syn_rd_en;  a.syn_idx = syn_idx;
    a.cn_rd = cn_rd_en;    a.cn_idx = cn_idx;
    a.cn_wr = cn_wr_en;    a.cn_wr_idx = cn_wr_idx;
    a.vn_rd = vn_rd_en;    a.vn_idx = vn_idx;
    a.vn_wr = vn_wr_en;    a.vn_wr_idx = vn_wr_idx;
    a.done = done;         a.success = success;
    a.iterations = iterations;
    return a;
  endfunction

  // Indices only carry meaning while their strobe is high.
  function automatic obs_t sample();
    obs_t a;
    a = sample_raw();
    if (!a.llr_wr) a.llr_addr = '0;
    if (!a.syn_rd) a.syn_idx = '0;
    if (!a.cn_rd)  a.cn_idx = '0;
    if (!a.cn_wr)  a.cn_wr_idx = '0;
    if (!a.vn_rd)  a.vn_idx = '0;
    if (!a.vn_wr)  a.vn_wr_idx = '0;
    return a;
  endfunction

  function automatic logic [M-1:0] mask_for(input int mode, input int pass);
    case (mode)
      0:       return 6'b000000;
      1:       return (pass < 3) ? 6'b010000 : 6'b000000;
      2:       return 6'b111111;
      default: return ($urandom_range(0, 2) == 0) ? 6'b000000 : 6'($urandom);
    endcase
  endfunction

  task automatic push(input obs_t r, input bit pf);
    exp_tr[tr_len] = r;
    pf_tr[tr_len]  = pf;
    tr_len++;
  endtask

  // One scan pass: K issues, then P drain cycles; write-back lags issue by P cycles.
  task automatic push_pass(input logic [2:0] ph, input int k, input logic [M-1:0] mask,
                           input int it);
    for (int i = 0; i < k + P; i++) begin
      obs_t r;
      bit   pf;
      r = '0;
      pf = 1'($urandom);
      r.phase = ph;
      r.busy = 1'b1;
      r.iterations = 5'(it);
      if (i < k) begin
        if (ph == 3'd2) begin r.syn_rd = 1'b1; r.syn_idx = 3'(i); end
        if (ph == 3'd3) begin r.cn_rd = 1'b1;  r.cn_idx = 3'(i);  end
        if (ph == 3'd4) begin r.vn_rd = 1'b1;  r.vn_idx = 4'(i);  end
      end
      if (i >= P && i - P < k) begin
        if (ph == 3'd2) pf = mask[i-P];
        if (ph == 3'd3) begin r.cn_wr = 1'b1; r.cn_wr_idx = 3'(i - P); end
        if (ph == 3'd4) begin r.vn_wr = 1'b1; r.vn_wr_idx = 4'(i - P); end
      end
      push(r, pf);
    end
  endtask

  task automatic build(input int mode, input int abort_at);
    int          it, pass;
    bit          succ, fin;
    logic [M-1:0] mask;
    obs_t        r;
    tr_len = 0;
    it = 0;
    succ = 1'b0;
    for (int a = 0; a < N; a++) begin
      r = '0;
      r.phase = 3'd1; r.busy = 1'b1; r.llr_wr = 1'b1; r.llr_addr = 4'(a);
      push(r, 1'($urandom));
    end
    if (EarlyTerm) begin
      pass = 0;
      fin = 1'b0;
      while (!fin) begin
        mask = mask_for(mode, pass);
        push_pass(3'd2, M, mask, it);
        pass++;
        if (mask == '0) begin
          succ = 1'b1; fin = 1'b1;
        end else if (it == MAXI) begin
          succ = 1'b0; fin = 1'b1;
        end else begin
          push_pass(3'd3, M, '0, it);
          push_pass(4'd4 == 4 ? 3'd4 : 3'd4, N, '0, it);
          if (it < MAXI) it++;
        end
      end
    end else begin
      for (int i = 0; i < MAXI; i++) begin
        push_pass(3'd3, M, '0, it);
        push_pass(3'd4, N, '0, it);
        it++;
      end
      mask = mask_for(mode, 0);
      push_pass(3'd2, M, mask, it);
      succ = (mask == '0);
    end
    done_idx = tr_len;
    abort_idx = abort_at;
    if (abort_at == -2) abort_idx = $urandom_range(0, done_idx - 1);
    if (abort_idx >= 0 && abort_idx < done_idx) begin
      tr_len = abort_idx + 1;
      it = int'(exp_tr[abort_idx].iterations);
      succ = 1'b0;
      done_idx = tr_len;
    end else begin
      abort_idx = -1;
    end
    r = '0;
    r.phase = 3'd5; r.busy = 1'b1; r.done = 1'b1; r.success = succ; r.iterations = 5'(it);
    push(r, 1'($urandom));
    for (int i = 0; i < 2; i++) begin
      r = '0;
      r.success = succ; r.iterations = 5'(it);
      push(r, 1'($urandom));
    end
  endtask

  // Pulses start, then walks the expected trace; stop_at < 0 runs it to the end.
  task automatic run_frame(input int stop_at, input int start_in, output int done_at,
                           output bit d_succ, output logic [4:0] d_iter);
    obs_t a;
    done_at = -1;
    d_succ = 1'b0;
    d_iter = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < tr_len; k++) begin
      if (k == stop_at) break;
      a = sample();
      checks++;
      if (a !== exp_tr[k]) begin
        errors++;
        $display("FAIL trace t+%0d: got %h want %h", k + 1, a, exp_tr[k]);
      end
      if (a.done && done_at < 0) begin
        done_at = k + 1;
        d_succ = a.success;
        d_iter = a.iterations;
      end
      parity_fail = pf_tr[k];
      abort = (k == abort_idx) || ((k >= done_idx) && 1'($urandom));
      start = (k == start_in);
      @(posedge clk); #1;
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    int          done_at, vn_first;
    bit          d_succ;
    logic [4:0]  d_iter;
    obs_t        a;
    checks = 0;
    errors = 0;
    rst = 1'b0; start = 1'b0; abort = 1'b0; parity_fail = 1'b0;
    #2 rst = 1'b1;
    #2;
    a = sample_raw();
    check_int("reset_outputs_zero", int'(a), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    a = sample_raw();
    check_int("idle_after_reset", int'(a), 0);

    if (EarlyTerm) begin
      tab[0] = '{0, -1, 21, 1, 0};
      tab[1] = '{1, -1, 111, 1, 3};
      tab[2] = '{2, -1, 921, 0, 30};
      tab[3] = '{2, 24, 26, 0, 0};
      tab[4] = '{0, -1, 21, 1, 0};
      tab[5] = '{3, -1, 0, 0, 0};
      tab[6] = '{3, -2, 0, 0, 0};
      tab[7] = '{3, -2, 0, 0, 0};
      ntab = 8;
    end else begin
      tab[0] = '{0, -1, 681, 1, 30};
      tab[1] = '{1, -1, 681, 0, 30};
      tab[2] = '{2, 16, 18, 0, 0};
      tab[3] = '{3, -1, 0, 0, 0};
      tab[4] = '{3, -2, 0, 0, 0};
      ntab = 5;
    end

    for (int v = 0; v < ntab; v++) begin
      build(tab[v].mode, tab[v].abort_at);
      run_frame(-1, -1, done_at, d_succ, d_iter);
      if (tab[v].exp_done > 0) begin
        check_int($sformatf("vec%0d_done_cycle", v), done_at, tab[v].exp_done);
        check_int($sformatf("vec%0d_success", v), int'(d_succ), tab[v].exp_succ);
        check_int($sformatf("vec%0d_iterations", v), int'(d_iter), tab[v].exp_iter);
      end
    end

    // start pulsed mid-VN is ignored, then reset mid-VN clears everything at once.
    build(2, -1);
    vn_first = EarlyTerm ? (N + 2 * (M + P)) : (N + (M + P));
    run_frame(vn_first + 6, vn_first + 2, done_at, d_succ, d_iter);
    #2 rst = 1'b1;
    #1;
    a = sample_raw();
    check_int("async_reset_mid_vn", int'(a), 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      a = sample_raw();
      check_int($sformatf("held_reset_%0d", c), int'(a), 0);
    end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_int($sformatf("no_done_after_reset_%0d", c), int'({phase, done, busy}), 0);
    end

    build(1, -1);
    run_frame(-1, -1, done_at, d_succ, d_iter);
    check_int("post_reset_frame_done_seen", int'(done_at > 0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ldpc_iter_scheduler.md
# ldpc_iter_scheduler

Sequencing controller for the serial LDPC min-sum datapath: one shared check-node unit, one variable-node unit, and BRAM message and codeword memories. On a start pulse it schedules LLR load, the syndrome check, and alternating check-node and variable-node passes. It issues row/column indices plus read and write-back strobes, tracks the iteration count, and reports success when the syndrome is zero. It replaces the ad-hoc FSM embedded in the decoder top, so the datapath becomes a pure index-driven slave.

## Interface
- N, 12, codeword length (variable nodes)
- M, 6, number of checks
- LOG2N, 4, width of variable index
- LOG2M, 3, width of check index
- MAX_ITER, 30, iteration limit
- LOG2MAX_ITER, 5, iteration counter width
- PIPE_LAT, 2, cycles from a read strobe to the datapath result and write-back (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin decoding a frame; sampled only in IDLE
- abort  in  1  terminate current frame
- parity_fail  in  1  per-check syndrome bit; valid on cycles where syn_rd_en delayed by PIPE_LAT is high
- phase  out  3  0 IDLE, 1 LOAD, 2 SYN, 3 CN, 4 VN, 5 DONE
- busy  out  1  high in every state except IDLE
- llr_wr_en  out  1  write channel LLR into v_msg/dec_cw at llr_addr
- llr_addr  out  LOG2N  LLR load address
- syn_rd_en  out  1  read codeword bits of check syn_idx
- cn_rd_en  out  1  read v_msg words for check cn_idx
- cn_wr_en  out  1  write c_msg for check cn_wr_idx
- vn_rd_en  out  1  read c_msg words for variable vn_idx
- vn_wr_en  out  1  write v_msg and hard decision for variable vn_wr_idx
- syn_idx, cn_idx, cn_wr_idx  out  LOG2M  check indices
- vn_idx, vn_wr_idx  out  LOG2N  variable indices
- done  out  1  one-cycle pulse at end of frame
- success  out  1  final syndrome zero; held until next accepted start
- iterations  out  LOG2MAX_ITER  completed CN+VN iterations; held until next accepted start

## Operation
- Reset: state IDLE. All outputs are 0, including the delay lines, the iteration counter and the syndrome accumulator.
- IDLE, start=1: next state LOAD. Clear success, iterations and the accumulator.
- LOAD: llr_wr_en=1 for N consecutive cycles, llr_addr 0..N-1. Next state SYN.
- Every scan pass (SYN, CN, VN) has the same structure:
  - Issue cycles: K issue cycles, index 0..K-1 (K=M for SYN/CN, K=N for VN), with rd_en=1.
  - Drain: PIPE_LAT drain cycles with rd_en=0.
  - Write-back: wr_en/wr_idx are rd_en/idx delayed exactly PIPE_LAT cycles by a shift register.
  - Length: each pass lasts K+PIPE_LAT cycles.
- SYN:
  - Accumulator is cleared on entry.
  - Each delayed syn_rd_en cycle ORs parity_fail into the accumulator.
  - At pass end:
    - Accumulator 0: DONE, success=1.
    - Otherwise, iterations==MAX_ITER: DONE, success=0.
    - Otherwise: CN.
- CN pass, then VN pass. At VN end, iterations increments (saturating at MAX_ITER), then SYN.
- DONE: done=1 for exactly one cycle, then IDLE.
- abort=1 in LOAD/SYN/CN/VN:
  - Next state DONE with success=0, iterations frozen.
  - All delay lines are flushed, so no write strobe issues after the abort cycle.
  - abort in IDLE or DONE is ignored.
- start while busy is ignored. start and abort together in IDLE: start wins.

## Timing
- Output type: all outputs are registered, and phase equals the current state.
- Start acceptance: start sampled at edge t. LOAD issue cycles are t+1..t+N.
- Pass lengths:
  - SYN: M+PIPE_LAT
  - CN: M+PIPE_LAT
  - VN: N+PIPE_LAT
  - One iteration: 2M+N+3·PIPE_LAT cycles, including the following SYN.
- parity_fail sampling: sampled only on delayed-syn_rd_en cycles. Any other value is don't-care.
- Last write-back: the final write-back of a pass occurs in its last drain cycle. The next pass's first read follows immediately, so there is no read-before-write hazard.
- Reset mid-pass: all strobes drop asynchronously, and no done pulse is issued.

## Configuration
- LDPC_SCHED_EARLY_TERM_EN defined:
  - Flow as above, with a SYN pass after LOAD and after every iteration.
  - Decoding stops early on a zero syndrome.
- Undefined:
  - Flow is LOAD → (CN → VN)×MAX_ITER → SYN → DONE.
  - iterations always ends at MAX_ITER unless aborted.
  - success reflects only the final syndrome.

## Test plan
Defaults for all tests: N=12, M=6, PIPE_LAT=2, MAX_ITER=30, start at edge t.
- EARLY_TERM_EN, parity_fail=0 always → LOAD t+1..t+12, SYN t+13..t+20, done at t+21, success=1, iterations=0, no cn/vn strobes.
- EARLY_TERM_EN, parity_fail=1 only for check 4 during the first 3 SYN passes → done at t+111, success=1, iterations=3. Also check cn_wr_idx lags cn_idx by 2 cycles.
- EARLY_TERM_EN, parity_fail=1 always → 31 SYN passes, done with success=0, iterations=30.
- abort in 5th CN issue cycle → no cn_wr_en after that cycle, done next cycle, success=0, iterations unchanged. Then start again → iterations cleared to 0.
- start pulsed in VN; rst asserted mid-VN → start ignored. On rst, all outputs are 0 immediately, phase=0, no done pulse.
- Macro undefined, parity_fail=0 → no SYN until the end, done at t+681, success=1, iterations=30.
